// File: rtl/rect_list_plotter_if.sv
// Pixel-plotter bus: draw request, rectangle list and the x/y/colour/plot write port with ready.
// The master drives the request side and ready; the slave (the plotter) drives pixels and status.
interface rect_list_plotter_if #(
    parameter int NUM_RECTS = 3,
    parameter int COORD_W   = 10,
    parameter int OFF_W     = 7,
    parameter int DIM_W     = 7,
    parameter int COLOR_W   = 3
);
    localparam int R = 2*OFF_W + 2*DIM_W + COLOR_W;

    logic                   go;
    logic                   erase;
    logic [COORD_W-1:0]     origin_x;
    logic [COORD_W-1:0]     origin_y;
    logic [COLOR_W-1:0]     bg_color;
    logic [NUM_RECTS*R-1:0] rect_desc;
    logic                   ready;
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [COLOR_W-1:0]     color;
    logic                   plot;
    logic                   busy;
    logic                   done;

    modport master (
        output go, erase, origin_x, origin_y, bg_color, rect_desc, ready,
        input  x, y, color, plot, busy, done
    );

    modport slave (
        input  go, erase, origin_x, origin_y, bg_color, rect_desc, ready,
        output x, y, color, plot, busy, done
    );
endinterface

// File: rtl/rect_list_plotter.sv
// Draws a list of filled rectangles relative to a latched origin, one pixel per accepted cycle,
// with screen clipping, zero-size skipping and an erase mode that paints every pixel in bg_color.
module rect_list_plotter #(
    parameter int NUM_RECTS = 3,
    parameter int COORD_W   = 10,
    parameter int OFF_W     = 7,
    parameter int DIM_W     = 7,
    parameter int COLOR_W   = 3,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic clk,
    input  logic reset_n,
    rect_list_plotter_if.slave bus
);
    localparam int R     = 2*OFF_W + 2*DIM_W + COLOR_W;
    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
    localparam int SW    = COORD_W + 1;
    localparam logic [SW-1:0]    SCR_W    = SW'(SCREEN_W);
    localparam logic [SW-1:0]    SCR_H    = SW'(SCREEN_H);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_NEXT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIM_W-1:0]       col_q, col_d;
    logic [DIM_W-1:0]       row_q, row_d;
    logic [COORD_W-1:0]     org_x_q, org_y_q;
    logic                   erase_q;
    logic [COLOR_W-1:0]     bg_q;
    logic [NUM_RECTS*R-1:0] desc_q;
    logic [COORD_W-1:0]     x_hold_q, y_hold_q;
    logic [COLOR_W-1:0]     color_hold_q;

    logic [OFF_W-1:0]   off_x_a [NUM_RECTS];
    logic [OFF_W-1:0]   off_y_a [NUM_RECTS];
    logic [DIM_W-1:0]   w_a     [NUM_RECTS];
    logic [DIM_W-1:0]   h_a     [NUM_RECTS];
    logic [COLOR_W-1:0] c_a     [NUM_RECTS];

    generate
        for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_unpack
            assign off_x_a[gi] = desc_q[gi*R                   +: OFF_W];
            assign off_y_a[gi] = desc_q[gi*R + OFF_W           +: OFF_W];
            assign w_a[gi]     = desc_q[gi*R + 2*OFF_W         +: DIM_W];
            assign h_a[gi]     = desc_q[gi*R + 2*OFF_W + DIM_W +: DIM_W];
            assign c_a[gi]     = desc_q[gi*R + 2*OFF_W + 2*DIM_W +: COLOR_W];
        end
    endgenerate

    logic [OFF_W-1:0]   cur_off_x, cur_off_y;
    logic [DIM_W-1:0]   cur_w, cur_h;
    logic [COLOR_W-1:0] cur_c;

    assign cur_off_x = off_x_a[idx_q];
    assign cur_off_y = off_y_a[idx_q];
    assign cur_w     = w_a[idx_q];
    assign cur_h     = h_a[idx_q];
    assign cur_c     = c_a[idx_q];

    // One extra bit keeps the carry so coordinates that wrap past 2^COORD_W clip instead of aliasing.
    logic [SW-1:0]      sum_x, sum_y;
    logic               clipped;
    logic [COLOR_W-1:0] pix_color;

    assign sum_x = {1'b0, org_x_q}
                 + {{(SW-OFF_W){1'b0}}, cur_off_x}
                 + {{(SW-DIM_W){1'b0}}, col_q};
    assign sum_y = {1'b0, org_y_q}
                 + {{(SW-OFF_W){1'b0}}, cur_off_y}
                 + {{(SW-DIM_W){1'b0}}, row_q};
    assign clipped   = (sum_x >= SCR_W) || (sum_y >= SCR_H);
    assign pix_color = erase_q ? bg_q : cur_c;

    logic               plot_c, busy_c, done_c;
    logic [COORD_W-1:0] x_c, y_c;
    logic [COLOR_W-1:0] color_c;
    logic               advance;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        plot_c  = 1'b0;
        done_c  = 1'b0;
        busy_c  = (state_q != S_IDLE);
        x_c     = x_hold_q;
        y_c     = y_hold_q;
        color_c = color_hold_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                col_d = '0;
                row_d = '0;
                if (cur_w == '0 || cur_h == '0) state_d = S_NEXT;
                else                            state_d = S_DRAW;
            end
            S_DRAW: begin
                x_c     = sum_x[COORD_W-1:0];
                y_c     = sum_y[COORD_W-1:0];
                color_c = pix_color;
                plot_c  = !clipped;
                // Clipped pixels are skipped unconditionally; visible ones wait for the sink.
                advance = (plot_c && bus.ready) || clipped;
                if (advance) begin
                    if (col_q == cur_w - DIM_W'(1)) begin
                        col_d = '0;
                        if (row_q == cur_h - DIM_W'(1)) state_d = S_NEXT;
                        else                             row_d   = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Draw parameters are captured once so the host may change the inputs mid-draw.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            org_x_q <= '0;
            org_y_q <= '0;
            erase_q <= 1'b0;
            bg_q    <= '0;
            desc_q  <= '0;
        end else if (state_q == S_IDLE && bus.go) begin
            org_x_q <= bus.origin_x;
            org_y_q <= bus.origin_y;
            erase_q <= bus.erase;
            bg_q    <= bus.bg_color;
            desc_q  <= bus.rect_desc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_hold_q     <= '0;
            y_hold_q     <= '0;
            color_hold_q <= '0;
        end else if (state_q == S_DRAW) begin
            x_hold_q     <= x_c;
            y_hold_q     <= y_c;
            color_hold_q <= color_c;
        end
    end

    assign bus.x     = x_c;
    assign bus.y     = y_c;
    assign bus.color = color_c;
    assign bus.plot  = plot_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
endmodule
